// File: rtl/mem_stage_lsu_if.sv
// Memory-stage LSU bundle: EX/MEM inputs, data-memory port and writeback outputs.
// The slave modport is the LSU's view; master is the surrounding pipeline/memory.
interface mem_stage_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  ex_valid;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic [2:0]            ex_funct3;
  logic [ADDR_WIDTH-1:0] ex_alu_result;
  logic [DATA_WIDTH-1:0] ex_store_data;
  logic [4:0]            ex_rd;
  logic                  lsu_ready;

  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [3:0]            dmem_be;
  logic [DATA_WIDTH-1:0] dmem_wdata;
  logic                  dmem_gnt;
  logic                  dmem_rvalid;
  logic [DATA_WIDTH-1:0] dmem_rdata;

  logic                  wb_valid;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  lsu_fault;

  modport slave (
    input  ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result,
           ex_store_data, ex_rd, dmem_gnt, dmem_rvalid, dmem_rdata,
    output lsu_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_rd, wb_data, lsu_fault
  );

  modport master (
    output ex_valid, ex_mem_read, ex_mem_write, ex_funct3, ex_alu_result,
           ex_store_data, ex_rd, dmem_gnt, dmem_rvalid, dmem_rdata,
    input  lsu_ready, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
           wb_valid, wb_rd, wb_data, lsu_fault
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: req/gnt/rvalid data-memory port, load alignment
// and extension, fault detection, and pass-through of non-memory results.
module mem_stage_lsu #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_stage_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            be_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [2:0]            funct3_q;
  logic [4:0]            rd_q;
  logic                  we_q;

  logic                  accept, is_mem, fault;
  logic                  bad_funct3, misaligned;
  logic [3:0]            be_calc;
  logic [DATA_WIDTH-1:0] wdata_calc, rshift, load_ext;

  assign accept         = bus.ex_valid && (state == IDLE);
  assign is_mem         = bus.ex_mem_read || bus.ex_mem_write;
  assign bus.lsu_ready  = (state == IDLE);
  assign bus.dmem_req   = (state == REQ);
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
  assign bus.dmem_be    = be_q;
  assign bus.dmem_wdata = wdata_q;

  // Decode of the incoming instruction: legality, byte lanes and store data.
  always_comb begin
    bad_funct3 = 1'b0;
    if (bus.ex_mem_read)
      bad_funct3 = (bus.ex_funct3 == 3'b011) || (bus.ex_funct3[2:1] == 2'b11);
    if (bus.ex_mem_write)
      bad_funct3 = bad_funct3 || (bus.ex_funct3 >= 3'b011);
    misaligned = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_alu_result[0]) ||
                 ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_alu_result[1:0] != 2'b00));
    fault = (bus.ex_mem_read && bus.ex_mem_write) || bad_funct3 || misaligned;

    case (bus.ex_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << bus.ex_alu_result[1:0];
        wdata_calc = {4{bus.ex_store_data[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << bus.ex_alu_result[1:0];
        wdata_calc = {2{bus.ex_store_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = bus.ex_store_data;
      end
    endcase
  end

  // Load data: shift the addressed lane down, then sign- or zero-extend.
  always_comb begin
    rshift = bus.dmem_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q[1:0])
      2'b00:   load_ext = {{24{~funct3_q[2] & rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = {{16{~funct3_q[2] & rshift[15]}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && is_mem && !fault) next_state = REQ;
      REQ:     if (bus.dmem_gnt) next_state = we_q ? IDLE : WAIT_R;
      WAIT_R:  if (bus.dmem_rvalid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latches and registered writeback; wb_valid is cleared every cycle
  // so it only ever pulses for one clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      funct3_q      <= '0;
      rd_q          <= '0;
      we_q          <= 1'b0;
      bus.wb_valid  <= 1'b0;
      bus.wb_rd     <= '0;
      bus.wb_data   <= '0;
      bus.lsu_fault <= 1'b0;
    end else begin
      bus.wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              bus.wb_valid  <= 1'b1;
              bus.wb_rd     <= bus.ex_rd;
              bus.wb_data   <= DATA_WIDTH'(bus.ex_alu_result);
              bus.lsu_fault <= 1'b0;
            end else if (fault) begin
              bus.wb_valid  <= 1'b1;
              bus.wb_rd     <= '0;
              bus.wb_data   <= DATA_WIDTH'(bus.ex_alu_result);
              bus.lsu_fault <= 1'b1;
            end else begin
              addr_q   <= bus.ex_alu_result;
              be_q     <= be_calc;
              wdata_q  <= wdata_calc;
              funct3_q <= bus.ex_funct3;
              rd_q     <= bus.ex_rd;
              we_q     <= bus.ex_mem_write;
            end
          end
        end
        REQ: begin
          if (bus.dmem_gnt && we_q) begin
            bus.wb_valid  <= 1'b1;
            bus.wb_rd     <= '0;
            bus.wb_data   <= '0;
            bus.lsu_fault <= 1'b0;
          end
        end
        WAIT_R: begin
          if (bus.dmem_rvalid) begin
            bus.wb_valid  <= 1'b1;
            bus.wb_rd     <= rd_q;
            bus.wb_data   <= load_ext;
            bus.lsu_fault <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu: pass-through, loads, stores,
// faults, grant/rvalid wait states and reset during an outstanding load.
module tb_mem_stage_lsu;
  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  mem_stage_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_stage_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ex_valid      = 1'b0;
    bus.ex_mem_read   = 1'b0;
    bus.ex_mem_write  = 1'b0;
    bus.ex_funct3     = 3'b000;
    bus.ex_alu_result = '0;
    bus.ex_store_data = '0;
    bus.ex_rd         = '0;
    bus.dmem_gnt      = 1'b0;
    bus.dmem_rvalid   = 1'b0;
    bus.dmem_rdata    = '0;
  endtask

  task automatic issue(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
    bus.ex_valid      = 1'b1;
    bus.ex_mem_read   = rd_en;
    bus.ex_mem_write  = wr_en;
    bus.ex_funct3     = f3;
    bus.ex_alu_result = addr;
    bus.ex_store_data = sdata;
    bus.ex_rd         = rd;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    checks++;
    if (bus.lsu_ready !== 1'b1 || bus.dmem_req !== 1'b0 || bus.wb_valid !== 1'b0 ||
        bus.wb_data !== 32'h0 || bus.lsu_fault !== 1'b0 || bus.dmem_be !== 4'h0)
      $display("[TB] FAIL reset_state: ready=%b req=%b wbv=%b wbd=%h flt=%b be=%b, required 1 0 0 0 0 0000",
               bus.lsu_ready, bus.dmem_req, bus.wb_valid, bus.wb_data, bus.lsu_fault, bus.dmem_be);
    else passed++;
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_data !== 32'h1234 ||
          bus.lsu_fault !== 1'b0 || bus.lsu_ready !== 1'b1 || bus.dmem_req !== 1'b0)
        $display("[TB] FAIL passthrough_%0d: wbv=%b rd=%0d data=%h flt=%b ready=%b req=%b, required 1 5 00001234 0 1 0",
                 i, bus.wb_valid, bus.wb_rd, bus.wb_data, bus.lsu_fault, bus.lsu_ready, bus.dmem_req);
      else passed++;
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0)
      $display("[TB] FAIL passthrough_end: wb_valid=%b, required 0", bus.wb_valid);
    else passed++;
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data);
    issue(1'b1, 1'b0, f3, 32'h0000_0103, 32'h0, 5'd7);
    tick();
    idle_inputs();
    checks++;
    if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b0 || bus.dmem_addr !== 32'h100 ||
        bus.dmem_be !== 4'b1000 || bus.lsu_ready !== 1'b0)
      $display("[TB] FAIL load_byte_req f3=%b: req=%b we=%b addr=%h be=%b ready=%b, required 1 0 00000100 1000 0",
               f3, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.lsu_ready);
    else passed++;
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h80FF_0000;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.wb_valid !== 1'b0)
      $display("[TB] FAIL load_byte_wait f3=%b: req=%b wbv=%b, required 0 0", f3, bus.dmem_req, bus.wb_valid);
    else passed++;
    tick();
    idle_inputs();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp_data || bus.wb_rd !== 5'd7 || bus.lsu_fault !== 1'b0)
      $display("[TB] FAIL load_byte_wb f3=%b: wbv=%b data=%h rd=%0d flt=%b, required 1 %h 7 0",
               f3, bus.wb_valid, bus.wb_data, bus.wb_rd, bus.lsu_fault, exp_data);
    else passed++;
    tick();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.lsu_ready !== 1'b1)
      $display("[TB] FAIL load_byte_after f3=%b: wbv=%b ready=%b, required 0 1", f3, bus.wb_valid, bus.lsu_ready);
    else passed++;
  endtask

  task automatic test_store_half();
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd9);
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dmem_gnt = 1'b1;
      checks++;
      if (bus.dmem_req !== 1'b1 || bus.dmem_we !== 1'b1 || bus.dmem_addr !== 32'h200 ||
          bus.dmem_be !== 4'b1100 || bus.dmem_wdata !== 32'hABCD_ABCD || bus.lsu_ready !== 1'b0)
        $display("[TB] FAIL store_half_hold_%0d: req=%b we=%b addr=%h be=%b wdata=%h ready=%b, required 1 1 00000200 1100 abcdabcd 0",
                 i, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be, bus.dmem_wdata, bus.lsu_ready);
      else passed++;
      tick();
    end
    bus.dmem_gnt = 1'b0;
    checks++;
    if (bus.dmem_req !== 1'b0 || bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0 ||
        bus.lsu_fault !== 1'b0 || bus.lsu_ready !== 1'b1)
      $display("[TB] FAIL store_half_wb: req=%b wbv=%b rd=%0d flt=%b ready=%b, required 0 1 0 0 1",
               bus.dmem_req, bus.wb_valid, bus.wb_rd, bus.lsu_fault, bus.lsu_ready);
    else passed++;
    tick();
  endtask

  task automatic test_store_byte();
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_005A, 5'd3);
    tick();
    idle_inputs();
    bus.dmem_gnt = 1'b1;
    checks++;
    if (bus.dmem_be !== 4'b0010 || bus.dmem_wdata !== 32'h5A5A_5A5A || bus.dmem_addr !== 32'h10)
      $display("[TB] FAIL store_byte_lanes: be=%b wdata=%h addr=%h, required 0010 5a5a5a5a 00000010",
               bus.dmem_be, bus.dmem_wdata, bus.dmem_addr);
    else passed++;
    tick();
    bus.dmem_gnt = 1'b0;
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_rd !== 5'd0)
      $display("[TB] FAIL store_byte_wb: wbv=%b rd=%0d, required 1 0", bus.wb_valid, bus.wb_rd);
    else passed++;
    tick();
  endtask

  task automatic test_faults();
    logic [31:0] addrs [3];
    logic [1:0]  rw    [3];
    logic [2:0]  f3s   [3];
    addrs = '{32'h6, 32'h10, 32'h20};
    rw    = '{2'b10, 2'b11, 2'b01};
    f3s   = '{3'b010, 3'b010, 3'b011};
    for (int i = 0; i < 3; i++) begin
      issue(rw[i][1], rw[i][0], f3s[i], addrs[i], 32'hFFFF_FFFF, 5'd12);
      tick();
      idle_inputs();
      checks++;
      if (bus.dmem_req !== 1'b0 || bus.wb_valid !== 1'b1 || bus.lsu_fault !== 1'b1 ||
          bus.wb_data !== addrs[i] || bus.wb_rd !== 5'd0 || bus.lsu_ready !== 1'b1)
        $display("[TB] FAIL fault_%0d: req=%b wbv=%b flt=%b data=%h rd=%0d ready=%b, required 0 1 1 %h 0 1",
                 i, bus.dmem_req, bus.wb_valid, bus.lsu_fault, bus.wb_data, bus.wb_rd, bus.lsu_ready, addrs[i]);
      else passed++;
      tick();
    end
  endtask

  task automatic test_load_wait();
    issue(1'b1, 1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd11);
    tick();
    idle_inputs();
    bus.dmem_gnt    = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1111_2222;
    tick();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.wb_valid !== 1'b0 || bus.dmem_req !== 1'b0 || bus.lsu_ready !== 1'b0)
        $display("[TB] FAIL lhu_wait_%0d: wbv=%b req=%b ready=%b, required 0 0 0",
                 i, bus.wb_valid, bus.dmem_req, bus.lsu_ready);
      else passed++;
      tick();
    end
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hBEEF_0000;
    tick();
    idle_inputs();
    checks++;
    if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h0000_BEEF || bus.wb_rd !== 5'd11)
      $display("[TB] FAIL lhu_wb: wbv=%b data=%h rd=%0d, required 1 0000beef 11",
               bus.wb_valid, bus.wb_data, bus.wb_rd);
    else passed++;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.wb_valid !== 1'b0 || bus.dmem_req !== 1'b0)
        $display("[TB] FAIL spurious_rvalid_%0d: wbv=%b req=%b, required 0 0", i, bus.wb_valid, bus.dmem_req);
      else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 5'd9);
    tick();
    idle_inputs();
    bus.dmem_gnt = 1'b1;
    tick();
    bus.dmem_gnt = 1'b0;
    checks++;
    if (bus.lsu_ready !== 1'b0)
      $display("[TB] FAIL reset_mid_pre: ready=%b, required 0", bus.lsu_ready);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.lsu_ready !== 1'b1 || bus.dmem_req !== 1'b0 || bus.wb_valid !== 1'b0 ||
        bus.wb_data !== 32'h0 || bus.dmem_addr !== 32'h0)
      $display("[TB] FAIL reset_mid_async: ready=%b req=%b wbv=%b data=%h addr=%h, required 1 0 0 0 0",
               bus.lsu_ready, bus.dmem_req, bus.wb_valid, bus.wb_data, bus.dmem_addr);
    else passed++;
    #1;
    rst_n = 1'b1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h1234_5678;
    tick();
    idle_inputs();
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.lsu_ready !== 1'b1)
      $display("[TB] FAIL reset_mid_after: wbv=%b ready=%b, required 0 1", bus.wb_valid, bus.lsu_ready);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_passthrough();
    test_load_byte(3'b000, 32'hFFFF_FF80);
    test_load_byte(3'b100, 32'h0000_0080);
    test_store_half();
    test_store_byte();
    test_faults();
    test_load_wait();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit, directly downstream of the execute-stage ALU. It consumes the ALU result as an effective address, or as a pass-through value for non-memory instructions. It drives a request/grant/rvalid data-memory port, then aligns and sign- or zero-extends load data. Upstream pipeline stages stall while a memory access is outstanding.

Parameters:
- ADDR_WIDTH, 32, byte-address width of ex_alu_result and dmem_addr
- DATA_WIDTH, 32, data word width; fixed at 32 in this revision

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX/MEM holds a valid instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_funct3  in  3  RV32I width/sign code (LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010)
- ex_alu_result  in  32  effective address, or result for non-memory instructions
- ex_store_data  in  32  rs2 value for stores
- ex_rd  in  5  destination register
- lsu_ready  out  1  can accept this cycle; upstream stall = ~lsu_ready
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  store data, lane-replicated
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data word
- wb_valid  out  1  one-cycle pulse: result available
- wb_rd  out  5  destination register (0 for stores and faults)
- wb_data  out  32  writeback value
- lsu_fault  out  1  qualifies wb_valid; misaligned or illegal access

Behaviour:
- Reset: asynchronous on rst_n low. All outputs go to 0, state IDLE, lsu_ready=1. A reset mid-access abandons the access; no wb_valid.
- States: IDLE, REQ, WAIT_R. lsu_ready=1 only in IDLE.
- Accept condition: ex_valid && lsu_ready at a rising edge.
- Non-memory instruction (neither read nor write):
  - Next cycle: wb_valid=1, wb_rd=ex_rd, wb_data=ex_alu_result, lsu_fault=0.
  - State stays IDLE, giving back-to-back throughput of 1 per cycle.
- Fault checks run at accept:
  - Both mem_read and mem_write set.
  - Illegal funct3: load 011/110/111; store >=011.
  - Misalignment: half with addr[0]=1, word with addr[1:0]!=0.
  - On fault, next cycle: wb_valid=1, lsu_fault=1, wb_rd=0, wb_data=address. No dmem_req. Stay IDLE.
- Legal load or store: address, be, wdata, funct3 and rd are latched; go to REQ.
  - In REQ, dmem_req=1 with all dmem_* outputs held stable until dmem_gnt.
- Byte enables:
  - SB/LB/LBU: 0001<<addr[1:0]
  - SH/LH/LHU: 0011<<addr[1:0]
  - SW/LW: 1111
  - Loads drive dmem_be with the same values.
- Store wdata: SB replicates byte 4×; SH replicates half 2×; SW passes through.
- Store: on the gnt cycle, dmem_req drops next cycle and the state returns to IDLE. wb_valid=1 in that next cycle with wb_rd=0, lsu_fault=0. Store latency = 1 + grant wait + 1.
- Load: on the gnt cycle, go to WAIT_R with dmem_req=0.
  - On dmem_rvalid in WAIT_R: select byte or half by latched addr[1:0]; sign-extend for LB/LH, zero-extend for LBU/LHU.
  - Next cycle: wb_valid=1, wb_rd=latched rd, wb_data=extended value; state returns to IDLE.
  - dmem_rvalid is ignored outside WAIT_R. rvalid is never accepted in the gnt cycle.
  - Minimum load latency: accept → REQ(gnt) → WAIT_R(rvalid) → wb_valid, i.e. 3 cycles.
- wb_valid is a single-cycle pulse; all wb_* outputs are registered.
- ex_valid while not ready: ignored. Upstream holds the instruction (stall).

Test Plan:
- Non-memory pass-through: ex_alu_result=0x0000_1234, rd=5, three back-to-back cycles → three consecutive wb_valid pulses, wb_data=0x1234, lsu_ready stays 1.
- LB, addr 0x103, rdata 0x80FF_0000, immediate gnt and rvalid → be=1000, dmem_addr=0x100, wb_data=0xFFFF_FF80. Same with LBU → 0x0000_0080.
- SH, addr 0x202, store_data 0x1234_ABCD, gnt delayed 3 cycles → dmem_req held 4 cycles with stable addr=0x200, be=1100, wdata=0xABCD_ABCD; lsu_ready=0 throughout; wb_valid with rd=0.
- LW, addr 0x6 → no dmem_req; next cycle wb_valid=1, lsu_fault=1, wb_data=0x6. Repeat with mem_read=mem_write=1 → same fault.
- LHU, addr 0x2, rdata 0xBEEF_0000, rvalid 5 cycles after gnt → wb_data=0x0000_BEEF. Spurious rvalid pulsed while idle → no wb_valid.
- Reset mid-access: deassert rst_n while in WAIT_R → outputs 0 immediately, lsu_ready=1 after release, no wb_valid from the abandoned load.
